// File: rtl/mem_refill_arbiter.sv
// Shares one memory request/response port between the I$ and D$ refill engines.
// Define MEM_REFILL_ARB_RR_EN for round-robin tie-breaking; otherwise D$ always wins ties.
module mem_refill_arbiter #(
  parameter int REFILL_BEATS    = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int MEM_ADDR_BITS   = 32,
  parameter int DC_MEM_TAG_BITS = 4,
  parameter int MEM_TAG_BITS    = DC_MEM_TAG_BITS + 2
) (
  input  logic                       clk,
  input  logic                       reset,

  input  logic                       ic_mem_req_val,
  output logic                       ic_mem_req_rdy,
  input  logic [MEM_ADDR_BITS-1:0]   ic_mem_req_addr,
  output logic                       ic_mem_resp_val,
  output logic                       ic_mem_resp_last,

  input  logic                       dc_mem_req_val,
  output logic                       dc_mem_req_rdy,
  input  logic                       dc_mem_req_rw,
  input  logic [MEM_ADDR_BITS-1:0]   dc_mem_req_addr,
  input  logic [DC_MEM_TAG_BITS-1:0] dc_mem_req_tag,
  output logic                       dc_mem_resp_val,
  output logic                       dc_mem_resp_last,
  output logic [DC_MEM_TAG_BITS-1:0] dc_mem_resp_tag,

  output logic                       mem_req_val,
  input  logic                       mem_req_rdy,
  output logic                       mem_req_rw,
  output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
  output logic [MEM_TAG_BITS-1:0]    mem_req_tag,
  input  logic                       mem_resp_val,
  input  logic [MEM_TAG_BITS-1:0]    mem_resp_tag,

  output logic                       idle,
  output logic                       proto_err
);

  localparam int BEAT_W = (REFILL_BEATS > 1) ? $clog2(REFILL_BEATS) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(REFILL_BEATS - 1);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DC   = 2'd1,
    GNT_IC   = 2'd2
  } grant_e;

  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              ic_pend_q, ic_pend_d;
  logic              proto_err_q, proto_err_d;
  logic              prio;

  grant_e grant;
  logic   slot_free, dc_elig, ic_elig;
  logic   accept, rd_accept;
  logic   resp_fwd, resp_is_ic, beat_last, refill_done;

  // Eligibility looks only at registered counters, so a freed slot shows up next cycle.
  always_comb begin
    slot_free = (rd_cnt_q < MAX_CNT);
    dc_elig   = dc_mem_req_val & (dc_mem_req_rw | slot_free);
    ic_elig   = ic_mem_req_val & slot_free & ~ic_pend_q;
    grant     = GNT_NONE;
    if (dc_elig && ic_elig) begin
      grant = prio ? GNT_IC : GNT_DC;
    end else if (dc_elig) begin
      grant = GNT_DC;
    end else if (ic_elig) begin
      grant = GNT_IC;
    end
  end

  always_comb begin
    mem_req_val    = (grant != GNT_NONE);
    mem_req_rw     = 1'b0;
    mem_req_addr   = '0;
    mem_req_tag    = '0;
    dc_mem_req_rdy = 1'b0;
    ic_mem_req_rdy = 1'b0;
    case (grant)
      GNT_DC: begin
        mem_req_rw                         = dc_mem_req_rw;
        mem_req_addr                       = dc_mem_req_addr;
        mem_req_tag[DC_MEM_TAG_BITS-1:0]   = dc_mem_req_tag;
        dc_mem_req_rdy                     = mem_req_rdy;
      end
      GNT_IC: begin
        mem_req_addr                       = ic_mem_req_addr;
        mem_req_tag[MEM_TAG_BITS-1]        = 1'b1;
        ic_mem_req_rdy                     = mem_req_rdy;
      end
      default: ;
    endcase
  end

  // Beats with nothing outstanding are strays: dropped here and flagged below.
  always_comb begin
    resp_fwd         = mem_resp_val & (rd_cnt_q != '0);
    resp_is_ic       = mem_resp_tag[MEM_TAG_BITS-1];
    beat_last        = (beat_cnt_q == LAST_BEAT);
    refill_done      = resp_fwd & beat_last;
    ic_mem_resp_val  = resp_fwd & resp_is_ic;
    dc_mem_resp_val  = resp_fwd & ~resp_is_ic;
    ic_mem_resp_last = ic_mem_resp_val & beat_last;
    dc_mem_resp_last = dc_mem_resp_val & beat_last;
    dc_mem_resp_tag  = mem_resp_tag[DC_MEM_TAG_BITS-1:0];
  end

  logic unused_tag_bits;
  assign unused_tag_bits = ^mem_resp_tag[MEM_TAG_BITS-2:DC_MEM_TAG_BITS];

  always_comb begin
    accept    = mem_req_val & mem_req_rdy;
    rd_accept = accept & ((grant == GNT_IC) | ((grant == GNT_DC) & ~dc_mem_req_rw));

    rd_cnt_d = rd_cnt_q;
    case ({rd_accept, refill_done})
      2'b10:   rd_cnt_d = rd_cnt_q + CNT_W'(1);
      2'b01:   rd_cnt_d = rd_cnt_q - CNT_W'(1);
      default: rd_cnt_d = rd_cnt_q;
    endcase

    beat_cnt_d = beat_cnt_q;
    if (resp_fwd) begin
      beat_cnt_d = refill_done ? '0 : beat_cnt_q + BEAT_W'(1);
    end

    ic_pend_d = ic_pend_q;
    if (refill_done && resp_is_ic) begin
      ic_pend_d = 1'b0;
    end
    if (accept && (grant == GNT_IC)) begin
      ic_pend_d = 1'b1;
    end

    proto_err_d = proto_err_q | (mem_resp_val & (rd_cnt_q == '0));
  end

`ifdef MEM_REFILL_ARB_RR_EN
  logic prio_q, prio_d;

  // After an accept the loser gets priority; a waiting request keeps its priority.
  always_comb begin
    prio_d = prio_q;
    if (accept) begin
      prio_d = (grant == GNT_DC);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign prio = prio_q;
`else
  assign prio = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt_q    <= '0;
      beat_cnt_q  <= '0;
      ic_pend_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      ic_pend_q   <= ic_pend_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign idle      = (rd_cnt_q == '0) && (beat_cnt_q == '0);
  assign proto_err = proto_err_q;

endmodule
